// File: rtl/spi_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI memory-slave transaction controller:
//   - state_t          : controller state encoding
//   - RW_READ          : value of the R/W command bit that selects a read
//   - DEFAULT_*_BITS   : default command / data byte lengths
//   - counterWidth()   : bit-counter width able to hold max(addr, data) bits
// ---------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_GET,
        WRITE_COMMIT,
        DONE
    } state_t;

    localparam logic RW_READ = 1'b1;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 8;

    // The counter must be able to represent the largest target value itself,
    // hence the +1 before taking the log.
    function automatic int counterWidth(input int addrBits, input int dataBits);
        int maxBits;
        maxBits = (addrBits > dataBits) ? addrBits : dataBits;
        return $clog2(maxBits + 1);
    endfunction

endpackage

// File: rtl/spi_control_fsm_if.sv
// ---------------------------------------------------------------------------
// spi_control_fsm_if
// Bundles the conditioned SPI inputs and the transaction strobes of the
// controller.
//   master : drives cs_n / sclk_pos / sclk_neg / rw_bit, observes strobes
//   slave  : the controller side (consumes inputs, drives strobes and busy)
// Signals:
//   cs_n         conditioned chip select, active low
//   sclk_pos     one-cycle pulse on SCLK rising edge
//   sclk_neg     one-cycle pulse on SCLK falling edge
//   rw_bit       shift register parallel-out bit 0 (R/W bit of command)
//   addr_we      address latch write enable
//   sr_we        shift register parallel-load enable
//   dm_we        data memory write enable
//   miso_buff_en MISO tri-state buffer enable
//   busy         controller is not idle
// ---------------------------------------------------------------------------
interface spi_control_fsm_if;

    logic cs_n;
    logic sclk_pos;
    logic sclk_neg;
    logic rw_bit;
    logic addr_we;
    logic sr_we;
    logic dm_we;
    logic miso_buff_en;
    logic busy;

    modport master (
        output cs_n, sclk_pos, sclk_neg, rw_bit,
        input  addr_we, sr_we, dm_we, miso_buff_en, busy
    );

    modport slave (
        input  cs_n, sclk_pos, sclk_neg, rw_bit,
        output addr_we, sr_we, dm_we, miso_buff_en, busy
    );

endinterface

// File: rtl/spi_control_fsm_bit_counter.sv
// ---------------------------------------------------------------------------
// spi_bit_counter
// Counts qualifying SCLK pulses for the controller and flags the pulse that
// completes the current field.
// Ports:
//   Clk       system clock
//   Reset_n   synchronous active-low reset
//   i_clear   return the count to zero (wins over i_enable)
//   i_enable  count this cycle
//   i_target  number of pulses that complete the field
//   o_done    combinational: this enabled pulse brings the count to i_target
// ---------------------------------------------------------------------------
module spi_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_target,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_countNext;

    assign w_countNext = r_count + WIDTH'(1);

    // Done is flagged on the pulse itself so the controller can change state
    // on the same edge that would store the final count.
    assign o_done = i_enable && (w_countNext == i_target);

    // Count register. The controller clears it on every state change, which
    // also happens on the completing pulse, so the count never wraps.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_countNext;
        end
    end

endmodule

// File: rtl/spi_control_fsm.sv
// ---------------------------------------------------------------------------
// spi_control_fsm
// Transaction controller for the SPI memory slave. Watches the conditioned
// chip select and SCLK edge pulses, counts the command and data bits and
// issues the one-cycle strobes that move the command into the address latch,
// load read data into the shift register, commit write data to memory and
// enable the MISO driver.
// Ports:
//   Clk      system clock, all state changes on its rising edge
//   Reset_n  synchronous active-low reset
//   bus      spi_control_fsm_if.slave (cs_n, sclk_pos, sclk_neg, rw_bit in;
//            addr_we, sr_we, dm_we, miso_buff_en, busy out)
// Parameters:
//   ADDR_BITS  bits in the command byte (address + R/W, R/W is the LSB)
//   DATA_BITS  bits in the data byte
// ---------------------------------------------------------------------------
module spi_control_fsm
    import spi_pkg::*;
#(
    parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
    input  logic             Clk,
    input  logic             Reset_n,
    spi_control_fsm_if.slave bus
);

    localparam int              CW          = counterWidth(ADDR_BITS, DATA_BITS);
    localparam logic [CW-1:0]   ADDR_TARGET = CW'(ADDR_BITS);
    localparam logic [CW-1:0]   DATA_TARGET = CW'(DATA_BITS);

    state_t        r_state;
    state_t        w_nextState;
    logic          w_cntClear;
    logic          w_cntEnable;
    logic          w_cntDone;
    logic [CW-1:0] w_cntTarget;

    // State register. The R/W decision is taken on the edge that leaves
    // GOT_ADDR, so the command bit is effectively captured by this register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Pick which SCLK edge counts in the current state and how many of them
    // complete the field. Address and write data are sampled on rising edges,
    // read data is shifted out on falling edges; the other edge is ignored.
    always_comb begin
        w_cntEnable = 1'b0;
        w_cntTarget = DATA_TARGET;
        case (r_state)
            GET_ADDR: begin
                w_cntEnable = bus.sclk_pos;
                w_cntTarget = ADDR_TARGET;
            end
            WRITE_GET:  w_cntEnable = bus.sclk_pos;
            READ_SHIFT: w_cntEnable = bus.sclk_neg;
            default:    w_cntEnable = 1'b0;
        endcase
    end

    // Clearing on every state change means each field, and each transaction
    // following an abort, starts counting from zero.
    assign w_cntClear = (w_nextState != r_state) || (r_state == IDLE);

    spi_bit_counter #(
        .WIDTH (CW)
    ) u_bitCounter (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .i_clear  (w_cntClear),
        .i_enable (w_cntEnable),
        .i_target (w_cntTarget),
        .o_done   (w_cntDone)
    );

    // Next-state and Moore output decode. Outputs depend on r_state only.
    // Chip select going high overrides everything else so an aborted write
    // can never reach WRITE_COMMIT.
    always_comb begin
        w_nextState      = r_state;
        bus.addr_we      = 1'b0;
        bus.sr_we        = 1'b0;
        bus.dm_we        = 1'b0;
        bus.miso_buff_en = 1'b0;
        bus.busy         = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                w_nextState = GET_ADDR;
            end
            GET_ADDR: begin
                if (w_cntDone) begin
                    w_nextState = GOT_ADDR;
                end
            end
            GOT_ADDR: begin
                bus.addr_we = 1'b1;
                w_nextState = (bus.rw_bit == RW_READ) ? READ_LOAD : WRITE_GET;
            end
            READ_LOAD: begin
                bus.sr_we   = 1'b1;
                w_nextState = READ_SHIFT;
            end
            READ_SHIFT: begin
                bus.miso_buff_en = 1'b1;
                if (w_cntDone) begin
                    w_nextState = DONE;
                end
            end
            WRITE_GET: begin
                if (w_cntDone) begin
                    w_nextState = WRITE_COMMIT;
                end
            end
            WRITE_COMMIT: begin
                bus.dm_we   = 1'b1;
                w_nextState = DONE;
            end
            DONE: begin
                w_nextState = DONE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (bus.cs_n) begin
            w_nextState = IDLE;
        end
    end

endmodule
